// File: rtl/pipe_shifter.sv
// -----------------------------------------------------------------------------
// pipe_shifter
//
// Pipelined barrel shifter with valid/ready handshakes on both sides.
// The operation runs through SHW = log2(WIDTH) register stages. Stage k
// applies a shift or rotate of 2^k when in_amt[k] is set. The amount-overflow
// bit in_amt[SHW] (amount >= WIDTH) travels with the operation and is resolved
// in the last stage. A result appears exactly SHW cycles after acceptance when
// the consumer does not stall. A new operation can be accepted every cycle.
//
// Operations (in_op):
//   2'b00 LSL : logical shift left, zero fill, signed-overflow flag
//   2'b01 LSR : logical shift right, zero fill
//   2'b10 ASR : arithmetic shift right, fills with the sign captured at entry
//   2'b11 ROR : rotate right by in_amt mod WIDTH (only when
//               PIPE_SHIFTER_ROTATE_EN is defined). Otherwise the operand
//               passes through unchanged with out_ov = 0.
//
// Configuration macro: PIPE_SHIFTER_ROTATE_EN (undefined by default).
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   an operation is presented
//   in_ready   out  the pipeline can accept an operation this cycle
//   in_data    in   operand, WIDTH bits
//   in_amt     in   shift amount, SHW+1 bits (0 .. 2*WIDTH-1)
//   in_op      in   operation select, 2 bits
//   out_valid  out  a result is presented
//   out_ready  in   the consumer takes the result
//   out_data   out  result, WIDTH bits
//   out_ov     out  signed overflow of an LSL result
//   busy       out  at least one stage holds a valid operation
// -----------------------------------------------------------------------------
module pipe_shifter #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW:0]     in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ov,
  output logic             busy
);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Stage registers. Index k holds the operation after stage k's shift.
  logic [SHW-1:0]   r_valid;
  logic [WIDTH-1:0] r_data [SHW];
  logic [1:0]       r_op   [SHW];
  logic [SHW:0]     r_amt  [SHW];
  logic             r_sign [SHW];   // operand MSB captured at acceptance
  logic             r_nz   [SHW];   // operand was non-zero at acceptance
  logic             r_ov   [SHW];   // LSL overflow accumulated so far

  // Next-state values produced by each stage's combinational step.
  logic [SHW-1:0]   w_nxt_valid;
  logic [WIDTH-1:0] w_nxt_data [SHW];
  logic [1:0]       w_nxt_op   [SHW];
  logic [SHW:0]     w_nxt_amt  [SHW];
  logic             w_nxt_sign [SHW];
  logic             w_nxt_nz   [SHW];
  logic             w_nxt_ov   [SHW];

  logic w_en;
  logic w_accept;

  // One conditional 2^sh step of the selected operation.
  // Returns {overflow_of_this_step, shifted_data}. For LSL the step
  // overflows when the bits shifted out and the new MSB are not all equal
  // to the current MSB. Chaining these checks across stages gives the
  // overflow of the whole shift.
  function automatic logic [WIDTH:0] stage_step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             sgn,
    input logic [SHW:0]     amt,
    input int               sh
  );
    logic [WIDTH-1:0]        r;
    logic                    ov;
    logic [2*WIDTH-1:0]      w_wide;
    logic signed [WIDTH-1:0] w_top;
    r      = d;
    ov     = 1'b0;
    w_wide = {2*WIDTH{1'b0}};
    w_top  = {WIDTH{1'b0}};
    if (amt[sh]) begin
      case (op)
        OP_LSL: begin
          r     = d << (1 << sh);
          w_top = $signed(d) >>> (WIDTH - 1 - (1 << sh));
          ov    = (w_top != {WIDTH{1'b0}}) && (w_top != {WIDTH{1'b1}});
        end
        OP_LSR: begin
          r = d >> (1 << sh);
        end
        OP_ASR: begin
          w_wide = {{WIDTH{sgn}}, d} >> (1 << sh);
          r      = w_wide[WIDTH-1:0];
        end
        OP_ROR: begin
`ifdef PIPE_SHIFTER_ROTATE_EN
          w_wide = {d, d} >> (1 << sh);
          r      = w_wide[WIDTH-1:0];
`else
          r = d;
`endif
        end
        default: begin
          r = d;
        end
      endcase
    end else begin
      r = d;
    end
    return {ov, r};
  endfunction

  // The pipeline advances as a whole unless a result is stuck at the output.
  assign w_en     = !r_valid[SHW-1] || out_ready;
  assign in_ready = w_en && !rst;
  assign w_accept = in_valid && in_ready;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic             w_src_valid;
    logic [WIDTH-1:0] w_src_data;
    logic [1:0]       w_src_op;
    logic [SHW:0]     w_src_amt;
    logic             w_src_sign;
    logic             w_src_nz;
    logic             w_src_ov;
    logic [WIDTH:0]   w_step;
    logic [WIDTH-1:0] w_data;
    logic             w_ov;

    if (k == 0) begin : g_head
      // The first stage takes the operation straight from the input port.
      assign w_src_valid = w_accept;
      assign w_src_data  = in_data;
      assign w_src_op    = in_op;
      assign w_src_amt   = in_amt;
      assign w_src_sign  = in_data[WIDTH-1];
      assign w_src_nz    = |in_data;
      assign w_src_ov    = 1'b0;
    end else begin : g_body
      assign w_src_valid = r_valid[k-1];
      assign w_src_data  = r_data[k-1];
      assign w_src_op    = r_op[k-1];
      assign w_src_amt   = r_amt[k-1];
      assign w_src_sign  = r_sign[k-1];
      assign w_src_nz    = r_nz[k-1];
      assign w_src_ov    = r_ov[k-1];
    end

    assign w_step = stage_step(w_src_data, w_src_op, w_src_sign, w_src_amt, k);

    // Stage result. The last stage also resolves amounts >= WIDTH and
    // produces the final overflow flag, which is non-zero only for LSL.
    always_comb begin
      w_data = w_step[WIDTH-1:0];
      w_ov   = w_src_ov | w_step[WIDTH];
      if (k == SHW - 1) begin
        if (w_src_amt[SHW]) begin
          case (w_src_op)
            OP_LSL:  w_data = {WIDTH{1'b0}};
            OP_LSR:  w_data = {WIDTH{1'b0}};
            OP_ASR:  w_data = {WIDTH{w_src_sign}};
            default: w_data = w_step[WIDTH-1:0];  // ROR uses amt mod WIDTH
          endcase
          w_ov = (w_src_op == OP_LSL) && w_src_nz;
        end else begin
          w_ov = (w_src_op == OP_LSL) && (w_src_ov | w_step[WIDTH]);
        end
      end else begin
        w_ov = w_src_ov | w_step[WIDTH];
      end
    end

    assign w_nxt_valid[k] = w_src_valid;
    assign w_nxt_data[k]  = w_data;
    assign w_nxt_op[k]    = w_src_op;
    assign w_nxt_amt[k]   = w_src_amt;
    assign w_nxt_sign[k]  = w_src_sign;
    assign w_nxt_nz[k]    = w_src_nz;
    assign w_nxt_ov[k]    = w_ov;
  end

  // Stage registers: cleared by reset, otherwise advance together on w_en.
  // Clearing the data as well keeps the idle outputs at a known zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= {SHW{1'b0}};
      for (int k = 0; k < SHW; k++) begin
        r_data[k] <= {WIDTH{1'b0}};
        r_op[k]   <= 2'b00;
        r_amt[k]  <= {(SHW+1){1'b0}};
        r_sign[k] <= 1'b0;
        r_nz[k]   <= 1'b0;
        r_ov[k]   <= 1'b0;
      end
    end else if (w_en) begin
      r_valid <= w_nxt_valid;
      for (int k = 0; k < SHW; k++) begin
        r_data[k] <= w_nxt_data[k];
        r_op[k]   <= w_nxt_op[k];
        r_amt[k]  <= w_nxt_amt[k];
        r_sign[k] <= w_nxt_sign[k];
        r_nz[k]   <= w_nxt_nz[k];
        r_ov[k]   <= w_nxt_ov[k];
      end
    end else begin
      r_valid <= r_valid;
    end
  end

  assign out_valid = r_valid[SHW-1];
  assign out_data  = r_data[SHW-1];
  assign out_ov    = r_ov[SHW-1];
  assign busy      = |r_valid;

endmodule

// File: tb/tb_pipe_shifter.sv
module tb_pipe_shifter;
  localparam int WIDTH = 16;
  localparam int SHW   = 4;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW:0]     in_amt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ov;
  logic             busy;

  pipe_shifter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ov(out_ov), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             ov;
    int               acc;
    logic             clean;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_stall = 1'b0;
  logic g_acc;
  logic g_rdy;
  logic             k_use = 1'b0;
  logic [WIDTH-1:0] k_d;
  logic             k_ov;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model computed from the arithmetic meaning of each operation.
  function automatic void model(input logic [WIDTH-1:0] d, input int amt, input logic [1:0] op,
                                output logic [WIDTH-1:0] r, output logic ov);
    longint          sd;
    longint          p;
    longint          lim;
    longint unsigned ud;
    int              s;
    sd  = longint'($signed(d));
    ud  = {48'd0, d};
    lim = longint'(1) <<< (WIDTH - 1);
    ov  = 1'b0;
    case (op)
      OP_LSL: begin
        r  = WIDTH'(ud << amt);
        p  = sd * (longint'(1) <<< amt);
        ov = (p >= lim) || (p < -lim);
      end
      OP_LSR: r = WIDTH'(ud >> amt);
      OP_ASR: r = WIDTH'(sd >>> amt);
      default: begin
`ifdef PIPE_SHIFTER_ROTATE_EN
        s = amt % WIDTH;
        r = WIDTH'((ud >> s) | (ud << (WIDTH - s)));
`else
        s = 0;
        r = d;
`endif
      end
    endcase
  endfunction

  task automatic k_set(input logic [WIDTH-1:0] d, input logic ov);
    k_use = 1'b1;
    k_d   = d;
    k_ov  = ov;
  endtask

  // One clock cycle: drive, check the visible state, update the scoreboard.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic [SHW:0] a,
                       input logic [1:0] o, input logic ordy, input logic r);
    exp_t             e;
    logic [WIDTH-1:0] md;
    logic             mov;
    rst = r; in_valid = v; in_data = d; in_amt = a; in_op = o; out_ready = ordy;
    #1;
    g_rdy = in_ready;
    chk("in_ready", in_ready, !r && (!out_valid || ordy));
    chk("busy", busy, q.size() != 0);
    if (prev_stall) chk("hold_valid", out_valid, 1'b1);
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out", out_valid, 1'b0);
      end else begin
        chk("out_data", out_data, q[0].d);
        chk("out_ov", out_ov, q[0].ov);
        if (ordy) begin
          if (q[0].clean) chk("latency", cyc - q[0].acc, SHW);
          void'(q.pop_front());
        end
      end
    end
    prev_stall = out_valid && !ordy;
    if (prev_stall) foreach (q[i]) q[i].clean = 1'b0;
    g_acc = v && in_ready;
    if (g_acc) begin
      model(d, int'(a), o, md, mov);
      e.d     = k_use ? k_d : md;
      e.ov    = k_use ? k_ov : mov;
      e.acc   = cyc;
      e.clean = 1'b1;
      q.push_back(e);
    end
    k_use = 1'b0;
    if (r) begin
      q.delete();
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 5'd0, OP_LSL, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_ov", out_ov, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
  endtask

  logic [WIDTH-1:0] sd_d  [6];
  logic [SHW:0]     sd_a  [6];
  logic [1:0]       sd_o  [6];

  initial begin
    int idx;
    int i;
    logic [WIDTH-1:0] rd;
    logic [SHW:0]     ra;
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; in_amt = 5'd0;
    in_op = OP_LSL; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();

    // LSL overflow and non-overflow cases, latency checked by the scoreboard
    k_set(16'h8002, 1'b1); cycle(1'b1, 16'h4001, 5'd1, OP_LSL, 1'b1, 1'b0);
    k_set(16'h000C, 1'b0); cycle(1'b1, 16'h0003, 5'd2, OP_LSL, 1'b1, 1'b0);
    idle(6);

    // Right shifts and amounts of WIDTH
    k_set(16'hF000, 1'b0); cycle(1'b1, 16'h8000, 5'd3,  OP_ASR, 1'b1, 1'b0);
    k_set(16'h1000, 1'b0); cycle(1'b1, 16'h8000, 5'd3,  OP_LSR, 1'b1, 1'b0);
    k_set(16'hFFFF, 1'b0); cycle(1'b1, 16'h8000, 5'd16, OP_ASR, 1'b1, 1'b0);
    k_set(16'h0000, 1'b0); cycle(1'b1, 16'h8000, 5'd16, OP_LSR, 1'b1, 1'b0);
    k_set(16'h0000, 1'b1); cycle(1'b1, 16'hFFFF, 5'd16, OP_LSL, 1'b1, 1'b0);
    idle(6);

    // Rotate, with and without the rotate feature
`ifdef PIPE_SHIFTER_ROTATE_EN
    k_set(16'h1000, 1'b0); cycle(1'b1, 16'h0001, 5'd4,  OP_ROR, 1'b1, 1'b0);
    k_set(16'h1000, 1'b0); cycle(1'b1, 16'h0001, 5'd20, OP_ROR, 1'b1, 1'b0);
`else
    k_set(16'h0001, 1'b0); cycle(1'b1, 16'h0001, 5'd4,  OP_ROR, 1'b1, 1'b0);
    k_set(16'h0001, 1'b0); cycle(1'b1, 16'h0001, 5'd20, OP_ROR, 1'b1, 1'b0);
`endif
    // Amount zero returns the operand unchanged for every op
    k_set(16'hC35A, 1'b0); cycle(1'b1, 16'hC35A, 5'd0, OP_LSL, 1'b1, 1'b0);
    k_set(16'hC35A, 1'b0); cycle(1'b1, 16'hC35A, 5'd0, OP_LSR, 1'b1, 1'b0);
    k_set(16'hC35A, 1'b0); cycle(1'b1, 16'hC35A, 5'd0, OP_ASR, 1'b1, 1'b0);
    k_set(16'hC35A, 1'b0); cycle(1'b1, 16'hC35A, 5'd0, OP_ROR, 1'b1, 1'b0);
    idle(6);

    // Six back-to-back operations with a 3-cycle output stall mid-stream
    for (int j = 0; j < 6; j++) begin
      sd_d[j] = 16'($urandom);
      sd_a[j] = 5'($urandom_range(31, 0));
      sd_o[j] = 2'($urandom_range(3, 0));
    end
    idx = 0;
    i   = 0;
    while (idx < 6 && i < 20) begin
      cycle(1'b1, sd_d[idx], sd_a[idx], sd_o[idx], !(i >= 4 && i <= 6), 1'b0);
      if (i >= 4 && i <= 6) chk("stall_in_ready", g_rdy, 1'b0);
      if (g_acc) idx++;
      i++;
    end
    chk("stall_all_sent", idx, 6);
    idle(8);

    // Reset with three operations in flight
    cycle(1'b1, 16'h1234, 5'd1, OP_LSL, 1'b1, 1'b0);
    cycle(1'b1, 16'h8765, 5'd5, OP_ASR, 1'b1, 1'b0);
    cycle(1'b1, 16'h0F0F, 5'd2, OP_LSR, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 5'd0, OP_LSL, 1'b1, 1'b1);
    chk_reset_state();
    idle(8);
    k_set(16'h0002, 1'b0); cycle(1'b1, 16'h0001, 5'd1, OP_LSL, 1'b1, 1'b0);
    idle(6);

    // Randomized traffic with random backpressure and boundary amounts
    for (int j = 0; j < 400; j++) begin
      case ($urandom_range(7, 0))
        0: ra = 5'd0;
        1: ra = 5'd15;
        2: ra = 5'd16;
        3: ra = 5'd31;
        default: ra = 5'($urandom_range(31, 0));
      endcase
      case ($urandom_range(7, 0))
        0: rd = 16'h0000;
        1: rd = 16'hFFFF;
        2: rd = 16'h8000;
        3: rd = 16'h7FFF;
        default: rd = 16'($urandom);
      endcase
      cycle($urandom_range(3, 0) != 0, rd, ra, 2'($urandom_range(3, 0)),
            $urandom_range(3, 0) != 0, 1'b0);
    end

    // Drain with a bounded wait
    i = 0;
    while (q.size() != 0 && i < 50) begin
      idle(1);
      i++;
    end
    chk("drain_empty", q.size(), 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
